// File: rtl/jpu_pkg.sv
// Shared jpu core types: memory access sizes, bus arbiter state/grant
// encodings and the misalignment rule used by both the arbiter and decode.
package jpu;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memsize_s;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } arbstate_s;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } arbgnt_s;

    // Byte accesses are always aligned; halves need addr[0]=0; words need addr[1:0]=0.
    // An undefined size encoding is treated like a word.
    function automatic logic misaligned(memsize_s sz, logic [1:0] a);
        case (sz)
            BYTE:    return 1'b0;
            HALF:    return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/jpu_bus_arb_lane.sv
// Big-endian lane steering: byte selects, store-data replication and
// load-data extraction (zero-extended) from access size and address low bits.
module jpu_lane_align
    import jpu::*;
(
    input  memsize_s    i_size,
    input  logic [1:0]  i_alo,
    input  logic        i_we,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_bus_rdata,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_byte_shift;

    // Byte lane k sits at bits [31-8k -: 8]; shifting by (3-k)*8 brings it to [7:0].
    assign w_byte_shift = i_bus_rdata >> {~i_alo, 3'b000};

    // Decode lane selects and steer data in both directions
    always_comb begin
        o_sel   = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_bus_rdata;
        case (i_size)
            BYTE: begin
                o_sel   = 4'b1000 >> i_alo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {24'h0, w_byte_shift[7:0]};
            end
            HALF: begin
                o_sel   = i_alo[1] ? 4'b0011 : 4'b1100;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {16'h0, (i_alo[1] ? i_bus_rdata[15:0] : i_bus_rdata[31:16])};
            end
            default: ;
        endcase
        // Loads drive no data so the bus does not see stale store values
        if (!i_we)
            o_wdata = '0;
    end

endmodule

// File: rtl/jpu_bus_arb.sv
// Two-requester Wishbone B4 classic arbiter: shares one master port between
// instruction fetch and load/store, flags misaligned accesses without a bus
// cycle, and turns slave errors / watchdog expiry into IBE/DBE pulses.
module jpu_bus_arb
    import jpu::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    output logic        if_adel,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [1:0]  dm_size,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic        dm_adel,
    output logic        dm_ades,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int WDW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

    arbstate_s      r_state;
    arbgnt_s        r_last;
    arbgnt_s        r_gnt;
    memsize_s       r_size;
    logic [1:0]     r_alo;
    logic [WDW-1:0] r_wdog;
    logic           r_cyc, r_we;
    logic [31:0]    r_adr, r_dat;
    logic [3:0]     r_sel;
    logic           r_if_ack, r_if_err, r_if_adel;
    logic           r_dm_ack, r_dm_err, r_dm_adel, r_dm_ades;
    logic [31:0]    r_if_rdata, r_dm_rdata;

    arbgnt_s        w_gnt;
    memsize_s       w_g_size, w_la_size;
    logic [31:0]    w_g_addr;
    logic           w_g_we, w_mis, w_wdog_hit;
    logic [1:0]     w_la_alo;
    logic [3:0]     w_sel;
    logic [31:0]    w_wdat, w_rdat;

    // DM wins by default; IF wins if DM had the previous grant and IF is waiting
    always_comb begin
        w_gnt = GNT_DM;
        if (if_req && (!dm_req || r_last == GNT_DM))
            w_gnt = GNT_IF;
    end

    assign w_g_size   = (w_gnt == GNT_IF) ? WORD : memsize_s'(dm_size);
    assign w_g_addr   = (w_gnt == GNT_IF) ? if_addr : dm_addr;
    assign w_g_we     = (w_gnt == GNT_DM) && dm_we;
    assign w_mis      = misaligned(w_g_size, w_g_addr[1:0]);
    assign w_wdog_hit = (TIMEOUT != 0) && (r_wdog == WD_LIMIT);

    // In IDLE the aligner shapes the incoming request; afterwards it
    // extracts read data using the latched size/offset.
    assign w_la_size = (r_state == IDLE) ? w_g_size : r_size;
    assign w_la_alo  = (r_state == IDLE) ? w_g_addr[1:0] : r_alo;

    jpu_lane_align u_lane (
        .i_size      (w_la_size),
        .i_alo       (w_la_alo),
        .i_we        (w_g_we),
        .i_wdata     (dm_wdata),
        .i_bus_rdata (wb_dat_i),
        .o_sel       (w_sel),
        .o_wdata     (w_wdat),
        .o_rdata     (w_rdat)
    );

    // Arbiter FSM with registered bus outputs and completion pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last     <= GNT_IF;
            r_gnt      <= GNT_IF;
            r_size     <= BYTE;
            r_alo      <= '0;
            r_wdog     <= '0;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= '0;
            r_sel      <= '0;
            r_dat      <= '0;
            r_if_ack   <= 1'b0;
            r_if_err   <= 1'b0;
            r_if_adel  <= 1'b0;
            r_dm_ack   <= 1'b0;
            r_dm_err   <= 1'b0;
            r_dm_adel  <= 1'b0;
            r_dm_ades  <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            // Pulses and read data live for exactly the DONE cycle
            r_if_ack   <= 1'b0;
            r_if_err   <= 1'b0;
            r_if_adel  <= 1'b0;
            r_dm_ack   <= 1'b0;
            r_dm_err   <= 1'b0;
            r_dm_adel  <= 1'b0;
            r_dm_ades  <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            case (r_state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        r_gnt  <= w_gnt;
                        r_last <= w_gnt;
                        if (w_mis) begin
                            r_state <= DONE;
                            if (w_gnt == GNT_IF) r_if_adel <= 1'b1;
                            else if (dm_we)      r_dm_ades <= 1'b1;
                            else                 r_dm_adel <= 1'b1;
                        end else begin
                            r_state <= BUS;
                            r_cyc   <= 1'b1;
                            r_we    <= w_g_we;
                            r_adr   <= {w_g_addr[31:2], 2'b00};
                            r_sel   <= w_sel;
                            r_dat   <= w_wdat;
                            r_size  <= w_g_size;
                            r_alo   <= w_g_addr[1:0];
                            r_wdog  <= '0;
                        end
                    end
                end
                BUS: begin
                    if (wb_err_i || wb_ack_i || w_wdog_hit) begin
                        r_state <= DONE;
                        r_cyc   <= 1'b0;
                        r_we    <= 1'b0;
                        // Error outranks a simultaneous ack; no ack means watchdog
                        if (wb_err_i || !wb_ack_i) begin
                            if (r_gnt == GNT_IF) r_if_err <= 1'b1;
                            else                 r_dm_err <= 1'b1;
                        end else if (r_gnt == GNT_IF) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= w_rdat;
                        end else begin
                            r_dm_ack   <= 1'b1;
                            r_dm_rdata <= w_rdat;
                        end
                    end else begin
                        r_wdog <= r_wdog + WDW'(1);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign wb_we_o  = r_we;
    assign wb_adr_o = r_adr;
    assign wb_sel_o = r_sel;
    assign wb_dat_o = r_dat;
    assign if_ack   = r_if_ack;
    assign if_err   = r_if_err;
    assign if_adel  = r_if_adel;
    assign if_rdata = r_if_rdata;
    assign dm_ack   = r_dm_ack;
    assign dm_err   = r_dm_err;
    assign dm_adel  = r_dm_adel;
    assign dm_ades  = r_dm_ades;
    assign dm_rdata = r_dm_rdata;

endmodule

// File: tb/tb_jpu_bus_arb.sv
// Bench for jpu_bus_arb: directed scenarios plus a randomized run checked
// against a transaction-level model of grant order and lane mapping.
module tb_jpu_bus_arb;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [1:0]  dm_size = 2'd0;
    logic        if_ack, if_err, if_adel, dm_ack, dm_err, dm_adel, dm_ades;
    logic [31:0] if_rdata, dm_rdata;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
    logic [6:0]  pv;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    jpu_bus_arb #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .if_err(if_err), .if_adel(if_adel),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .dm_adel(dm_adel), .dm_ades(dm_ades),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    // {if_ack, if_err, if_adel, dm_ack, dm_err, dm_adel, dm_ades}
    assign pv = {if_ack, if_err, if_adel, dm_ack, dm_err, dm_adel, dm_ades};

    // ---------------- behavioural Wishbone slave ----------------
    bit          s_rand = 0, s_hang = 0, s_ack_en = 1, s_err_en = 0;
    int          s_wait = 0, s_cnt = 0, stab_bad = 0;
    logic [31:0] s_data = '0;
    bit          cap_valid = 0, cap_we;
    logic [31:0] cap_adr, cap_dat, cap_data;
    logic [3:0]  cap_sel;

    always @(negedge clk) begin
        if (wb_cyc_o) begin
            if (s_cnt == 0) begin
                if (s_rand) begin
                    s_data = $urandom;
                    s_wait = $urandom_range(0, 3);
                end
                cap_valid = 1; cap_we = wb_we_o; cap_adr = wb_adr_o;
                cap_sel = wb_sel_o; cap_dat = wb_dat_o; cap_data = s_data;
            end else if (wb_we_o !== cap_we || wb_adr_o !== cap_adr ||
                         wb_sel_o !== cap_sel || wb_dat_o !== cap_dat || wb_stb_o !== 1'b1) begin
                stab_bad++;
            end
            wb_dat_i = s_data;
            if (!s_hang && s_cnt == s_wait) begin
                wb_ack_i = s_ack_en; wb_err_i = s_err_en;
            end else begin
                wb_ack_i = 0; wb_err_i = 0;
            end
            s_cnt++;
        end else begin
            wb_ack_i = 0; wb_err_i = 0; s_cnt = 0;
        end
    end

    // ---------------- reference model helpers ----------------
    function automatic int nbytes(logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_mis(logic [1:0] s, logic [31:0] a);
        return (a % nbytes(s)) != 0;
    endfunction

    function automatic logic [3:0] m_sel(logic [1:0] s, logic [31:0] a);
        int n = nbytes(s);
        int lo = int'(a % 4);
        return 4'(((1 << n) - 1) << (4 - n - lo));
    endfunction

    function automatic logic [31:0] m_dat(logic [1:0] s, logic [31:0] wd);
        int n = nbytes(s);
        if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_rdata(logic [1:0] s, logic [31:0] a, logic [31:0] d);
        int n = nbytes(s);
        int lo = int'(a % 4);
        longint mask = (64'd1 << (8 * n)) - 1;
        return 32'((longint'(d) >> (8 * (4 - n - lo))) & mask);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_dm(bit req, bit we, logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
        dm_req = req; dm_we = we; dm_size = sz; dm_addr = a; dm_wdata = wd;
    endtask

    task automatic quiet();
        if_req = 0; dm_req = 0; s_hang = 0; s_ack_en = 1; s_err_en = 0;
        step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 0; step(); step();
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o} !== '0)
            $display("FAIL reset_bus got=%b/%h/%h/%h exp=0", wb_cyc_o, wb_adr_o, wb_sel_o, wb_dat_o);
        checks++;
        if (pv !== 7'b0) $display("FAIL reset_pulses got=%b exp=0000000", pv);
        checks++;
        if ({if_rdata, dm_rdata} !== 64'h0) $display("FAIL reset_rdata got=%h/%h exp=0", if_rdata, dm_rdata);
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o} !== '0 || pv !== 7'b0 ||
            {if_rdata, dm_rdata} !== 64'h0) failures++;
        rst_n = 1; step();
        checks++;
        if (wb_cyc_o !== 1'b0) begin failures++; $display("FAIL reset_idle_cyc got=%b exp=0", wb_cyc_o); end
    endtask

    task automatic test_if_read();
        s_rand = 0; s_wait = 0; s_data = 32'hDEAD_BEEF;
        if_req = 1; if_addr = 32'h0000_0100;
        step();
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o} !== {3'b110, 32'h100, 4'hF}) begin
            failures++;
            $display("FAIL if_read_bus got=%b%b%b %h %h exp=110 00000100 f", wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o);
        end
        step();
        checks++;
        if (pv !== 7'b1000000 || if_rdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL if_read_ack got=%b %h exp=1000000 deadbeef", pv, if_rdata);
        end
        checks++;
        if (wb_cyc_o !== 1'b0 || dm_rdata !== 32'h0) begin
            failures++; $display("FAIL if_read_done got=cyc%b dm_rdata=%h exp=0/0", wb_cyc_o, dm_rdata);
        end
        step(); if_req = 0;
        checks++;
        if (pv !== 7'b0) begin failures++; $display("FAIL if_read_single got=%b exp=0", pv); end
        step();
    endtask

    task automatic test_both_store();
        s_data = 32'h0;
        set_dm(1, 1, 2'd0, 32'h0000_1003, 32'h0000_00AB);
        if_req = 1; if_addr = 32'h0000_0200;
        step();
        checks++;
        if ({wb_cyc_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o} !== {2'b11, 32'h1000, 4'b0001, 32'hABAB_ABAB}) begin
            failures++;
            $display("FAIL both_dm_bus got=%b%b %h %b %h exp=11 00001000 0001 abababab", wb_cyc_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o);
        end
        step();
        checks++;
        if (pv !== 7'b0001000) begin failures++; $display("FAIL both_dm_ack got=%b exp=0001000", pv); end
        step(); dm_req = 0;
        step();
        checks++;
        if ({wb_cyc_o, wb_we_o, wb_adr_o, wb_sel_o} !== {2'b10, 32'h200, 4'hF}) begin
            failures++; $display("FAIL both_if_bus got=%b%b %h %h exp=10 00000200 f", wb_cyc_o, wb_we_o, wb_adr_o, wb_sel_o);
        end
        step();
        checks++;
        if (pv !== 7'b1000000) begin failures++; $display("FAIL both_if_ack got=%b exp=1000000", pv); end
        step(); if_req = 0;
        step();
    endtask

    task automatic test_half_load();
        s_data = 32'h1234_8765;
        set_dm(1, 0, 2'd1, 32'h0000_2002, 32'h0);
        step();
        checks++;
        if (wb_sel_o !== 4'b0011 || wb_adr_o !== 32'h2000) begin
            failures++; $display("FAIL half_sel got=%b %h exp=0011 00002000", wb_sel_o, wb_adr_o);
        end
        step();
        checks++;
        if (pv !== 7'b0001000 || dm_rdata !== 32'h0000_8765) begin
            failures++; $display("FAIL half_rdata got=%b %h exp=0001000 00008765", pv, dm_rdata);
        end
        step(); dm_req = 0;
        step();
    endtask

    task automatic test_misaligned();
        set_dm(1, 1, 2'd2, 32'h0000_2001, 32'h1111_2222);
        step();
        checks++;
        if (pv !== 7'b0000001 || wb_cyc_o !== 1'b0) begin
            failures++; $display("FAIL mis_ades got=%b cyc=%b exp=0000001 cyc=0", pv, wb_cyc_o);
        end
        step(); dm_req = 0;
        checks++;
        if (pv !== 7'b0) begin failures++; $display("FAIL mis_ades_once got=%b exp=0", pv); end
        if_req = 1; if_addr = 32'h0000_0102;
        step();
        checks++;
        if (pv !== 7'b0010000 || wb_cyc_o !== 1'b0) begin
            failures++; $display("FAIL mis_adel got=%b cyc=%b exp=0010000 cyc=0", pv, wb_cyc_o);
        end
        step(); if_req = 0;
        step();
    endtask

    task automatic test_timeout();
        int c = 0, rise = -1, errc = -1;
        logic [6:0] got = '0;
        s_hang = 1;
        if_req = 1; if_addr = 32'h0000_0300;
        for (int i = 0; i < 30 && errc < 0; i++) begin
            step(); c++;
            if (rise < 0 && wb_cyc_o) rise = c;
            if (pv !== 7'b0) begin errc = c; got = pv; end
        end
        checks++;
        if (rise < 0 || errc < 0 || errc - rise != 5) begin
            failures++; $display("FAIL timeout_latency got=%0d exp=5 (rise=%0d err=%0d)", errc - rise, rise, errc);
        end
        checks++;
        if (got !== 7'b0100000) begin failures++; $display("FAIL timeout_pulse got=%b exp=0100000", got); end
        step();
        quiet();
    endtask

    task automatic test_ack_err();
        s_err_en = 1; s_ack_en = 1; s_wait = 0;
        set_dm(1, 0, 2'd2, 32'h0000_0400, 32'h0);
        step(); step();
        checks++;
        if (pv !== 7'b0000100) begin failures++; $display("FAIL ack_err_prio got=%b exp=0000100", pv); end
        step();
        quiet();
    endtask

    task automatic test_reset_mid_bus();
        logic [6:0] acc = '0;
        bit saw_cyc = 0;
        s_hang = 1;
        set_dm(1, 0, 2'd2, 32'h0000_0500, 32'h0);
        step();
        checks++;
        if (wb_cyc_o !== 1'b1) begin failures++; $display("FAIL rst_bus_start got=%b exp=1", wb_cyc_o); end
        rst_n = 0;
        step();
        checks++;
        if (wb_cyc_o !== 1'b0 || pv !== 7'b0) begin
            failures++; $display("FAIL rst_bus_abort got=cyc%b %b exp=cyc0 0000000", wb_cyc_o, pv);
        end
        rst_n = 1; dm_req = 0; s_hang = 0;
        for (int i = 0; i < 5; i++) begin
            step(); acc |= pv; saw_cyc |= wb_cyc_o;
        end
        checks++;
        if (acc !== 7'b0 || saw_cyc) begin
            failures++; $display("FAIL rst_no_completion got=%b cyc=%b exp=0000000 cyc=0", acc, saw_cyc);
        end
    endtask

    task automatic test_alternate();
        int n = 0;
        bit exp_dm, got_dm;
        s_rand = 1;
        set_dm(1, 0, 2'd2, 32'h0000_0800, 32'h0);
        if_req = 1; if_addr = 32'h0000_0900;
        for (int i = 0; i < 200 && n < 10; i++) begin
            step();
            if (pv !== 7'b0) begin
                exp_dm = (n % 2) == 0;
                got_dm = pv[3:0] != 4'b0;
                checks++;
                if (got_dm !== exp_dm || (pv !== 7'b1000000 && pv !== 7'b0001000)) begin
                    failures++; $display("FAIL alternate_%0d got=%b exp_dm=%0d", n, pv, exp_dm);
                end
                n++;
            end
        end
        checks++;
        if (n != 10) begin failures++; $display("FAIL alternate_count got=%0d exp=10", n); end
        step();
        quiet();
        s_rand = 0;
    endtask

    task automatic test_random();
        bit if_p = 0, dm_p = 0, inflight = 0, pred_dm = 0, last_dm = 0, defer = 0, mis, we;
        logic [1:0]  sz;
        logic [31:0] a, got_rd;
        logic [6:0]  expv;
        int done_n = 0, wait_n = 0;
        s_rand = 1; s_hang = 0; s_ack_en = 1; s_err_en = 0;
        if_req = 0; dm_req = 0;
        rst_n = 0; step(); rst_n = 1;
        cap_valid = 0; stab_bad = 0;
        for (int c = 0; c < 6000 && done_n < 150; c++) begin
            step();
            if (pv !== 7'b0) begin
                sz = pred_dm ? dm_size : 2'd2;
                a  = pred_dm ? dm_addr : if_addr;
                we = pred_dm && dm_we;
                mis = m_mis(sz, a);
                expv = pred_dm ? (mis ? (we ? 7'b0000001 : 7'b0000010) : 7'b0001000)
                               : (mis ? 7'b0010000 : 7'b1000000);
                checks++;
                if (pv !== expv || !inflight) begin
                    failures++; $display("FAIL rand_pulse_%0d got=%b exp=%b", done_n, pv, expv);
                end
                if (mis) begin
                    checks++;
                    if (cap_valid) begin failures++; $display("FAIL rand_mis_nobus_%0d got=bus exp=none", done_n); end
                end else begin
                    checks++;
                    if ({cap_valid, cap_we, cap_adr, cap_sel} !== {1'b1, we, a & 32'hFFFF_FFFC, m_sel(sz, a)}) begin
                        failures++;
                        $display("FAIL rand_bus_%0d got=%b%b %h %b exp=1%b %h %b", done_n, cap_valid, cap_we, cap_adr, cap_sel,
                                 we, a & 32'hFFFF_FFFC, m_sel(sz, a));
                    end
                    checks++;
                    got_rd = pred_dm ? dm_rdata : if_rdata;
                    if (we && cap_dat !== m_dat(sz, dm_wdata)) begin
                        failures++; $display("FAIL rand_wdat_%0d got=%h exp=%h", done_n, cap_dat, m_dat(sz, dm_wdata));
                    end else if (!we && got_rd !== m_rdata(sz, a, cap_data)) begin
                        failures++; $display("FAIL rand_rdata_%0d got=%h exp=%h", done_n, got_rd, m_rdata(sz, a, cap_data));
                    end
                end
                if (pred_dm) dm_p = 0; else if_p = 0;
                last_dm = pred_dm;
                inflight = 0; defer = 1; cap_valid = 0; done_n++;
            end else if (defer || !inflight) begin
                defer = 0;
                if (!if_p && $urandom_range(0, 2) != 0) begin
                    if_p = 1;
                    if_addr = $urandom;
                    if ($urandom_range(0, 3) != 0) if_addr[1:0] = 2'b00;
                end
                if (!dm_p && $urandom_range(0, 2) != 0) begin
                    dm_p = 1;
                    dm_we = 1'($urandom_range(0, 1));
                    dm_size = 2'($urandom_range(0, 2));
                    dm_addr = $urandom;
                    dm_wdata = $urandom;
                    if ($urandom_range(0, 1) == 1)
                        dm_addr = dm_addr - (dm_addr % nbytes(dm_size));
                end
                if_req = if_p; dm_req = dm_p;
                if (!inflight && (if_p || dm_p)) begin
                    pred_dm = dm_p && !(last_dm && if_p);
                    inflight = 1; wait_n = 0;
                end
            end else begin
                wait_n++;
                if (wait_n > 30) begin
                    failures++; $display("FAIL rand_stall got=no completion in 30 cycles exp=completion");
                    break;
                end
            end
        end
        checks++;
        if (done_n < 150) begin failures++; $display("FAIL rand_count got=%0d exp=150", done_n); end
        checks++;
        if (stab_bad != 0) begin failures++; $display("FAIL rand_bus_stable got=%0d exp=0", stab_bad); end
        quiet();
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_both_store();
        test_half_load();
        test_misaligned();
        test_timeout();
        test_ack_err();
        test_reset_mid_bus();
        test_alternate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
